// File: rtl/gb_pkg.sv
// Shared constants and state encodings for the cartridge loader path.
package gb_pkg;

  localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;
  localparam logic [23:0] MAX_ROM_LEN   = 24'h080000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_LEN2,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchronizer, oversample counter and deserializer.
module uart_rx import gb_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = 36
) (
  input  logic       clockgb,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int unsigned    CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta;
  logic          rx_sync;
  rx_state_t     st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign rx_byte = shreg;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clockgb or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
    end
  end

  // Deserializer: mid-bit sampling after a confirmed start bit, one-cycle strobes.
  always_ff @(posedge clockgb or posedge reset) begin
    if (reset) begin
      st           <= RX_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      unique case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_sync) st <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            st      <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) st <= RX_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            st  <= RX_IDLE;
            if (rx_sync) rx_valid     <= 1'b1;
            else         rx_frame_err <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cart_loader.sv
// Cartridge image loader: frames UART bytes (sync, 24-bit length, data,
// checksum) and streams the data into the banked-ROM SRAM write port.
module cart_loader import gb_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = 36,
  parameter logic [7:0]  SYNC_BYTE    = DEF_SYNC_BYTE
) (
  input  logic        clockgb,
  input  logic        reset,
  input  logic        prog,
  input  logic        UART_RX,
  output logic [18:0] wr_address,
  output logic [7:0]  wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic        error
);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_frame_err;

  load_state_t state;
  logic [23:0] length;
  logic [19:0] count;
  logic [7:0]  sum;
  logic        accept;
  logic        last_accept;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clockgb      (clockgb),
    .reset        (reset),
    .UART_RX      (UART_RX),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  // The accepted-write count doubles as the SRAM address of the next write.
  assign wr_address  = count[18:0];
  assign accept      = wr_valid && wr_ready;
  assign last_accept = accept && ((count + 20'd1) == length[19:0]);

  // Frame FSM with length/address counters, checksum and holding register.
  always_ff @(posedge clockgb or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      length   <= '0;
      count    <= '0;
      sum      <= '0;
      wr_data  <= '0;
      wr_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else if (!prog) begin
      state    <= ST_IDLE;
      length   <= '0;
      count    <= '0;
      sum      <= '0;
      wr_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      busy <= (state inside {ST_LEN0, ST_LEN1, ST_LEN2, ST_DATA, ST_CSUM});
      if (accept) begin
        wr_valid <= 1'b0;
        count    <= count + 20'd1;
      end
      unique case (state)
        ST_IDLE: begin
          if (rx_valid && rx_byte == SYNC_BYTE) state <= ST_LEN0;
        end
        ST_LEN0: begin
          if (rx_frame_err) begin
            state <= ST_ERROR;
            error <= 1'b1;
          end else if (rx_valid) begin
            length[7:0] <= rx_byte;
            state       <= ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (rx_frame_err) begin
            state <= ST_ERROR;
            error <= 1'b1;
          end else if (rx_valid) begin
            length[15:8] <= rx_byte;
            state        <= ST_LEN2;
          end
        end
        ST_LEN2: begin
          if (rx_frame_err) begin
            state <= ST_ERROR;
            error <= 1'b1;
          end else if (rx_valid) begin
            length[23:16] <= rx_byte;
            if ({rx_byte, length[15:0]} > MAX_ROM_LEN) begin
              state <= ST_ERROR;
              error <= 1'b1;
            end else if ({rx_byte, length[15:0]} == 24'd0) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (rx_frame_err) begin
            state    <= ST_ERROR;
            error    <= 1'b1;
            wr_valid <= 1'b0;
          end else if (rx_valid && last_accept) begin
            // Final write retires in the same cycle the next byte lands, so
            // that byte is the checksum rather than more data.
            if (rx_byte == sum) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end else if (rx_valid && wr_valid && !accept) begin
            state    <= ST_ERROR;
            error    <= 1'b1;
            wr_valid <= 1'b0;
          end else if (rx_valid) begin
            wr_data  <= rx_byte;
            wr_valid <= 1'b1;
            sum      <= sum + rx_byte;
          end else if (last_accept) begin
            state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (rx_frame_err) begin
            state <= ST_ERROR;
            error <= 1'b1;
          end else if (rx_valid) begin
            if (rx_byte == sum) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
        ST_DONE, ST_ERROR: begin
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader: table of framed loads plus corner sequences.
module tb_cart_loader;
  import gb_pkg::*;

  localparam int unsigned CPB = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog;
  logic        UART_RX;
  logic [18:0] wr_address;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic        error;

  int unsigned pass_cnt = 0;
  int unsigned tot_cnt  = 0;
  int unsigned rxv_cnt  = 0;

  logic [18:0] log_addr[$];
  logic [7:0]  log_data[$];

  typedef struct {
    int unsigned nb;
    logic [71:0] bytes;
    logic        rdy;
    int unsigned nw;
    logic [31:0] wdata;
    logic        edone;
    logic        eerr;
  } vec_t;

  vec_t vecs[6];

  cart_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clockgb    (clk),
    .reset      (reset),
    .prog       (prog),
    .UART_RX    (UART_RX),
    .wr_address (wr_address),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && wr_valid && wr_ready) begin
      log_addr.push_back(wr_address);
      log_data.push_back(wr_data);
    end
    if (dut.rx_valid) rxv_cnt <= rxv_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    UART_RX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (CPB) @(negedge clk);
    end
    UART_RX = stop;
    repeat (CPB) @(negedge clk);
    UART_RX = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  logic [7:0]  b;
  logic [71:0] nominal;

  initial begin
    vecs[0] = '{9, 72'hAA_44_33_22_11_00_00_04_A5, 1'b1, 4, 32'h44332211, 1'b1, 1'b0};
    vecs[1] = '{9, 72'hAB_44_33_22_11_00_00_04_A5, 1'b1, 4, 32'h44332211, 1'b0, 1'b1};
    vecs[2] = '{5, 72'h00_00_00_00_00_00_00_00_A5, 1'b1, 0, 32'h0,        1'b1, 1'b0};
    vecs[3] = '{4, 72'h00_00_00_00_00_08_00_01_A5, 1'b1, 0, 32'h0,        1'b0, 1'b1};
    vecs[4] = '{8, 72'h00_10_20_F0_00_00_02_A5_3C, 1'b1, 2, 32'h000020F0, 1'b1, 1'b0};
    vecs[5] = '{6, 72'h00_00_00_34_12_00_00_02_A5, 1'b0, 0, 32'h0,        1'b0, 1'b1};
    nominal = 72'hAA_44_33_22_11_00_00_04_A5;

    reset = 1'b1; prog = 1'b0; UART_RX = 1'b1; wr_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_addr", 32'(wr_address), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    check("rst_busy_done_err", {29'd0, busy, done, error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      prog = 1'b0;
      wr_ready = vecs[v].rdy;
      repeat (2) @(negedge clk);
      clear_log();
      prog = 1'b1;
      @(negedge clk);
      for (int k = 0; k < int'(vecs[v].nb); k++) begin
        b = vecs[v].bytes[8*k +: 8];
        send_byte(b, 1'b1);
      end
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_nwrites", v), 32'(log_addr.size()), 32'(vecs[v].nw));
      for (int i = 0; i < int'(vecs[v].nw) && i < log_addr.size(); i++) begin
        check($sformatf("v%0d_addr%0d", v, i), 32'(log_addr[i]), 32'(i));
        check($sformatf("v%0d_data%0d", v, i), 32'(log_data[i]), 32'(vecs[v].wdata[8*i +: 8]));
      end
      check($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].edone));
      check($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].eerr));
      check($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
      check($sformatf("v%0d_wr_valid", v), 32'(wr_valid), 32'd0);
      check($sformatf("v%0d_end_addr", v), 32'(wr_address), 32'(vecs[v].nw));
      // Dropping prog clears status on the very next edge.
      prog = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_abort_done", v), 32'(done), 32'd0);
      check($sformatf("v%0d_abort_error", v), 32'(error), 32'd0);
      check($sformatf("v%0d_abort_state", v), 32'(dut.state), 32'(ST_IDLE));
    end

    // Glitch in IDLE: short low pulse must not produce a byte.
    prog = 1'b1; wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    begin
      int unsigned base;
      base = rxv_cnt;
      UART_RX = 1'b0;
      repeat (3) @(negedge clk);
      UART_RX = 1'b1;
      repeat (12 * CPB) @(negedge clk);
      check("glitch_rx_valid", 32'(rxv_cnt - base), 32'd0);
    end
    check("glitch_state", 32'(dut.state), 32'(ST_IDLE));
    check("glitch_error", 32'(error), 32'd0);

    // Framing error while in LEN1.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h10, 1'b1);
    check("len1_busy", 32'(busy), 32'd1);
    send_byte(8'h00, 1'b0);
    check("frame_err_error", 32'(error), 32'd1);
    check("frame_err_done", 32'(done), 32'd0);
    check("frame_err_busy", 32'(busy), 32'd0);

    // Reset during DATA with a pending write, then a clean load from address 0.
    prog = 1'b0;
    @(negedge clk);
    prog = 1'b1; wr_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      b = nominal[8*k +: 8];
      send_byte(b, 1'b1);
    end
    check("pend_wr_valid", 32'(wr_valid), 32'd1);
    check("pend_wr_data", 32'(wr_data), 32'h11);
    check("pend_addr", 32'(wr_address), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_outputs",
          {wr_address, wr_data, wr_valid, busy, done, error}, 32'd0);
    @(negedge clk);
    reset = 1'b0; wr_ready = 1'b1;
    @(negedge clk);
    clear_log();
    for (int k = 0; k < 9; k++) begin
      b = nominal[8*k +: 8];
      send_byte(b, 1'b1);
    end
    repeat (4) @(negedge clk);
    check("post_rst_nwrites", 32'(log_addr.size()), 32'd4);
    if (log_addr.size() > 0) begin
      check("post_rst_addr0", 32'(log_addr[0]), 32'd0);
      check("post_rst_data0", 32'(log_data[0]), 32'h11);
    end
    check("post_rst_done", 32'(done), 32'd1);
    check("post_rst_error", 32'(error), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
